pipelined_addsub: RTL and testbench

//  Parametrised, pipelined two's-complement add/subtract unit; successor to the 8-bit ripple add/sub adder.

---
 rtl/pipelined_addsub_pkg.sv | 13 +
 rtl/addsub_slice.sv | 27 ++
 rtl/pipelined_addsub.sv | 133 +++++++++++++
 tb/tb_pipelined_addsub.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipelined_addsub_pkg.sv
// Shared definitions for the pipelined add/subtract unit: ALU op encodings
// and the full-adder cell used to build each carry-ripple slice.
package pipelined_addsub_pkg;

  localparam logic ALU_OP_ADD = 1'b0;
  localparam logic ALU_OP_SUB = 1'b1;

  // Full-adder cell: returns {carry_out, sum}.
  function automatic logic [1:0] fac(input logic x, input logic y, input logic ci);
    fac = {(x & y) | (ci & (x ^ y)), x ^ y ^ ci};
  endfunction

endpackage

// File: rtl/addsub_slice.sv
// Combinational SW-bit carry-ripple slice built from full-adder cells.
// Also exports the carry into the slice MSB so the top slice can derive signed overflow.
module addsub_slice
  import pipelined_addsub_pkg::*;
#(
  parameter int SW = 4
) (
  input  logic [SW-1:0] a_i,
  input  logic [SW-1:0] b_i,
  input  logic          cin_i,
  output logic [SW-1:0] sum_o,
  output logic          cout_o,
  output logic          cmsb_o
);

  logic [SW:0] c;

  assign c[0] = cin_i;

  for (genvar i = 0; i < SW; i++) begin : g_fac
    assign {c[i+1], sum_o[i]} = fac(a_i[i], b_i[i], c[i]);
  end

  assign cout_o = c[SW];
  assign cmsb_o = c[SW-1];

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined two's-complement add/subtract: WIDTH bits split into STAGES registered
// ripple slices, with skewed operand/result registers so each beat stays aligned.
module pipelined_addsub
  import pipelined_addsub_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int SW = (STAGES > 0) ? (WIDTH / STAGES) : 1;

  if ((STAGES < 1) || (STAGES > WIDTH) || ((WIDTH % STAGES) != 0)) begin : g_cfg_err
    $error("pipelined_addsub: WIDTH must be a multiple of STAGES and 1 <= STAGES <= WIDTH");
  end

  // Handshake: a beat moves in when in_valid && in_ready and out when
  // out_valid && out_ready. The whole pipe advances together whenever the
  // output register is empty or being drained; otherwise every register holds.
  logic             adv;
  logic [WIDTH-1:0] b_eff;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign b_eff    = (sub == ALU_OP_SUB) ? ~b : b;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = k * SW;
    localparam int HI = LO + SW;

    logic [WIDTH-1:LO] a_in;
    logic [WIDTH-1:LO] b_in;
    logic              cin;
    logic              valid_in;
    logic [SW-1:0]     s_sl;
    logic              co;
    logic              cmsb;
    logic [HI-1:0]     sum_d;
    logic [HI-1:0]     sum_q;
    logic              carry_q;
    logic              valid_q;

    if (k == 0) begin : g_first
      assign a_in     = a;
      assign b_in     = b_eff;
      assign cin      = (sub == ALU_OP_SUB);
      assign valid_in = in_valid;
      assign sum_d    = s_sl;
    end else begin : g_next
      assign a_in     = g_stage[k-1].g_skew.a_q;
      assign b_in     = g_stage[k-1].g_skew.b_q;
      assign cin      = g_stage[k-1].carry_q;
      assign valid_in = g_stage[k-1].valid_q;
      assign sum_d    = {s_sl, g_stage[k-1].sum_q};
    end

    addsub_slice #(.SW(SW)) u_slice (
      .a_i   (a_in[HI-1:LO]),
      .b_i   (b_in[HI-1:LO]),
      .cin_i (cin),
      .sum_o (s_sl),
      .cout_o(co),
      .cmsb_o(cmsb)
    );

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_q <= 1'b0;
        carry_q <= 1'b0;
        sum_q   <= '0;
      end else if (adv) begin
        valid_q <= valid_in;
        carry_q <= co;
        sum_q   <= sum_d;
      end
    end

    // Operand bits not yet consumed ride along one stage per cycle.
    if (HI < WIDTH) begin : g_skew
      logic [WIDTH-1:HI] a_q;
      logic [WIDTH-1:HI] b_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv) begin
          a_q <= a_in[WIDTH-1:HI];
          b_q <= b_in[WIDTH-1:HI];
        end
      end
    end

    if (k == STAGES - 1) begin : g_last
      logic ovf_q;
      logic zero_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ovf_q  <= 1'b0;
          zero_q <= 1'b0;
        end else if (adv) begin
          ovf_q  <= co ^ cmsb;
          zero_q <= ~|sum_d;
        end
      end
    end else begin : g_mid
      // Only the top slice's MSB carry matters for overflow.
      logic unused_cmsb;
      assign unused_cmsb = cmsb;
    end
  end

  assign out_valid = g_stage[STAGES-1].valid_q;
  assign sum       = g_stage[STAGES-1].sum_q;
  assign cout      = g_stage[STAGES-1].carry_q;
  assign ovf       = g_stage[STAGES-1].g_last.ovf_q;
  assign zero      = g_stage[STAGES-1].g_last.zero_q;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub: directed vector table, streaming, backpressure,
// async reset mid-stream, and two extra configurations (8/1 and 32/8).
module tb_pipelined_addsub;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- main DUT (16/4) ----------------
  logic        in_valid, in_ready, sub, out_valid, out_ready, cout, ovf, zero;
  logic [15:0] a, b, sum;

  pipelined_addsub #(.WIDTH(16), .STAGES(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
  );

  // ---------------- config 8/1 ----------------
  logic       c8_in_valid, c8_in_ready, c8_sub, c8_out_valid, c8_cout, c8_ovf, c8_zero;
  logic [7:0] c8_a, c8_b, c8_sum;

  pipelined_addsub #(.WIDTH(8), .STAGES(1)) u_c8 (
    .clk(clk), .rst(rst), .in_valid(c8_in_valid), .in_ready(c8_in_ready),
    .a(c8_a), .b(c8_b), .sub(c8_sub), .out_valid(c8_out_valid), .out_ready(1'b1),
    .sum(c8_sum), .cout(c8_cout), .ovf(c8_ovf), .zero(c8_zero)
  );

  // ---------------- config 32/8 ----------------
  logic        c32_in_valid, c32_in_ready, c32_sub, c32_out_valid, c32_cout, c32_ovf, c32_zero;
  logic [31:0] c32_a, c32_b, c32_sum;

  pipelined_addsub #(.WIDTH(32), .STAGES(8)) u_c32 (
    .clk(clk), .rst(rst), .in_valid(c32_in_valid), .in_ready(c32_in_ready),
    .a(c32_a), .b(c32_b), .sub(c32_sub), .out_valid(c32_out_valid), .out_ready(1'b1),
    .sum(c32_sum), .cout(c32_cout), .ovf(c32_ovf), .zero(c32_zero)
  );

  // ---------------- checking helpers ----------------
  int chk_cnt  = 0;
  int pass_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  typedef struct packed {
    logic        zero;
    logic        ovf;
    logic        cout;
    logic [31:0] sum;
  } res_t;

  // Reference: arithmetic sum plus sign-rule overflow on the effective operands.
  function automatic res_t model(input int w, input logic [31:0] x, input logic [31:0] y,
                                 input logic s);
    logic [31:0] mask, xx, yy;
    logic [32:0] full;
    res_t        r;
    mask   = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    xx     = x & mask;
    yy     = (s ? ~y : y) & mask;
    full   = {1'b0, xx} + {1'b0, yy} + {32'd0, s};
    r.sum  = full[31:0] & mask;
    r.cout = full[w];
    r.ovf  = (xx[w-1] == yy[w-1]) && (r.sum[w-1] != xx[w-1]);
    r.zero = (r.sum == 32'd0);
    return r;
  endfunction

  // ---------------- scoreboards ----------------
  logic [34:0] exp_q[$];
  int          pop_cyc_q[$];

  always @(negedge clk) begin : mon_main
    res_t e;
    if (rst) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("main_unexpected_beat", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("main_result", {45'd0, zero, ovf, cout, sum},
                {45'd0, e.zero, e.ovf, e.cout, e.sum[15:0]});
          pop_cyc_q.push_back(cyc);
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(16, {16'd0, a}, {16'd0, b}, sub));
    end
  end

  logic [34:0] exp8_q[$];
  int          st8_q[$];
  int          c8_pops = 0;

  always @(negedge clk) begin : mon_c8
    res_t e;
    int   st;
    if (rst) begin
      exp8_q.delete();
      st8_q.delete();
    end else begin
      if (c8_out_valid) begin
        if (exp8_q.size() == 0) begin
          check("c8_unexpected_beat", 64'd1, 64'd0);
        end else begin
          e  = exp8_q.pop_front();
          st = st8_q.pop_front();
          c8_pops++;
          check("c8_result", {53'd0, c8_zero, c8_ovf, c8_cout, c8_sum},
                {53'd0, e.zero, e.ovf, e.cout, e.sum[7:0]});
          check("c8_latency", 64'(cyc - st), 64'd1);
        end
      end
      if (c8_in_valid && c8_in_ready) begin
        exp8_q.push_back(model(8, {24'd0, c8_a}, {24'd0, c8_b}, c8_sub));
        st8_q.push_back(cyc);
      end
    end
  end

  logic [34:0] exp32_q[$];
  int          st32_q[$];
  int          c32_pops = 0;

  always @(negedge clk) begin : mon_c32
    res_t e;
    int   st;
    if (rst) begin
      exp32_q.delete();
      st32_q.delete();
    end else begin
      if (c32_out_valid) begin
        if (exp32_q.size() == 0) begin
          check("c32_unexpected_beat", 64'd1, 64'd0);
        end else begin
          e  = exp32_q.pop_front();
          st = st32_q.pop_front();
          c32_pops++;
          check("c32_result", {29'd0, c32_zero, c32_ovf, c32_cout, c32_sum},
                {29'd0, e.zero, e.ovf, e.cout, e.sum});
          check("c32_latency", 64'(cyc - st), 64'd8);
        end
      end
      if (c32_in_valid && c32_in_ready) begin
        exp32_q.push_back(model(32, c32_a, c32_b, c32_sub));
        st32_q.push_back(cyc);
      end
    end
  end

  // ---------------- directed vectors ----------------
  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
  } vec_t;

  vec_t vecs[10];

  // Offer one beat, then measure edges until out_valid and compare the result.
  task automatic send_and_check(input vec_t v, input string tag);
    int n;
    a        = v.a;
    b        = v.b;
    sub      = v.sub;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_latency"}, 64'(n), 64'd4);
    check({tag, "_sum"},  64'(sum),  64'(v.sum));
    check({tag, "_cout"}, 64'(cout), 64'(v.cout));
    check({tag, "_ovf"},  64'(ovf),  64'(v.ovf));
    check({tag, "_zero"}, 64'(zero), 64'(v.zero));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_sum"},       64'(sum),       64'd0);
    check({tag, "_flags"},     64'({cout, ovf, zero}), 64'd0);
    check({tag, "_in_ready"},  64'(in_ready),  64'd1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main_test
    logic [47:0] snap;
    int          n;
    vec_t        pv;

    //            a         b         sub   sum       cout  ovf   zero
    vecs[0] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};
    vecs[7] = '{16'h0F0F, 16'hF0F0, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{16'h1234, 16'h0034, 1'b1, 16'h1200, 1'b1, 1'b0, 1'b0};
    vecs[9] = '{16'h00F0, 16'h0010, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0};

    in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; out_ready = 1'b1;
    c8_in_valid = 1'b0; c8_a = '0; c8_b = '0; c8_sub = 1'b0;
    c32_in_valid = 1'b0; c32_a = '0; c32_b = '0; c32_sub = 1'b0;

    // Reset, checked before any clock edge.
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("reset");
    check("reset_c8_out_valid",  64'(c8_out_valid),  64'd0);
    check("reset_c32_out_valid", 64'(c32_out_valid), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_reset_outputs("post_reset");

    // Directed table.
    for (int i = 0; i < 10; i++) send_and_check(vecs[i], $sformatf("vec%0d", i));
    repeat (2) @(posedge clk); #1;

    // Back-to-back stream of 8 random beats.
    pop_cyc_q.delete();
    for (int i = 0; i < 8; i++) begin
      a        = 16'($urandom_range(0, 65535));
      b        = 16'($urandom_range(0, 65535));
      sub      = 1'($urandom_range(0, 1));
      in_valid = 1'b1;
      check("stream_in_ready", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (8) @(posedge clk); #1;
    check("stream_count", 64'(pop_cyc_q.size()), 64'd8);
    if (pop_cyc_q.size() == 8)
      check("stream_back_to_back", 64'(pop_cyc_q[7] - pop_cyc_q[0]), 64'd7);
    check("stream_queue_empty", 64'(exp_q.size()), 64'd0);

    // Backpressure: fill with 3 beats, stall 5 cycles with a 4th beat offered.
    pop_cyc_q.delete();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a        = 16'h1000 + 16'(i * 16'h0111);
      b        = 16'h0F0F;
      sub      = i[0];
      in_valid = 1'b1;
      check("bp_fill_in_ready", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("bp_out_valid", 64'(out_valid), 64'd1);
    snap     = {28'd0, out_valid, cout, ovf, zero, sum};
    a        = 16'hABCD;
    b        = 16'h1111;
    sub      = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_hold", {16'd0, 28'd0, out_valid, cout, ovf, zero, sum}, {16'd0, snap});
      check("bp_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk); #1;
    check("bp_count", 64'(pop_cyc_q.size()), 64'd4);
    check("bp_queue_empty", 64'(exp_q.size()), 64'd0);

    // Async reset with beats in flight.
    for (int i = 0; i < 5; i++) begin
      a        = 16'h1111 * 16'(i + 1);
      b        = 16'h0101;
      sub      = 1'b0;
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("pre_rst_out_valid", 64'(out_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("mid_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    check("post_mid_rst_idle", 64'(out_valid), 64'd0);
    pv = '{16'h4000, 16'h4000, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
    send_and_check(pv, "post_rst_beat");
    repeat (6) @(posedge clk); #1;
    check("post_rst_queue_empty", 64'(exp_q.size()), 64'd0);

    // Configuration sweep: 8/1 and 32/8 streams.
    for (int i = 0; i < 64; i++) begin
      c8_a   = 8'($urandom_range(0, 255));
      c8_b   = 8'($urandom_range(0, 255));
      c8_sub = 1'($urandom_range(0, 1));
      c32_a  = $urandom;
      c32_b  = $urandom;
      c32_sub = 1'($urandom_range(0, 1));
      if (i == 0) begin
        c8_a = 8'hFF; c8_b = 8'h01; c8_sub = 1'b0;
        c32_a = 32'hFFFF_FFFF; c32_b = 32'h1; c32_sub = 1'b0;
      end else if (i == 1) begin
        c8_a = 8'h80; c8_b = 8'h01; c8_sub = 1'b1;
        c32_a = 32'h7FFF_FFFF; c32_b = 32'h1; c32_sub = 1'b0;
      end else if (i == 2) begin
        c8_a = 8'h5A; c8_b = 8'h5A; c8_sub = 1'b1;
        c32_a = 32'h0000_0000; c32_b = 32'h1; c32_sub = 1'b1;
      end
      c8_in_valid  = 1'b1;
      c32_in_valid = 1'b1;
      @(posedge clk); #1;
    end
    c8_in_valid  = 1'b0;
    c32_in_valid = 1'b0;
    repeat (12) @(posedge clk); #1;
    check("c8_count",  64'(c8_pops),  64'd64);
    check("c32_count", 64'(c32_pops), 64'd64);
    check("c8_queue_empty",  64'(exp8_q.size()),  64'd0);
    check("c32_queue_empty", 64'(exp32_q.size()), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
